// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame FSM encoding, frame constants and scan codes
// also used by the downstream display decoder.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_DATA   = 4'b0010,
        ST_PARITY = 4'b0100,
        ST_STOP   = 4'b1000
    } ps2_state_e;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] LSHIFT       = 8'h12;
    localparam logic [7:0] LCTRL        = 8'h14;

    // Odd-parity test over data plus parity bit.
    function automatic logic odd_ones(input logic [DATA_BITS:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Circular byte FIFO with wrapping pointers; a write into a full FIFO is
// only accepted when a read happens in the same cycle.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [DATA_BITS-1:0]      wr_data,
    input  logic                      rd_en,
    output logic [DATA_BITS-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 do_wr, do_rd;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_rd    = rd_en & ~empty;
        do_wr    = wr_en & (~full | do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: pin sync, frame FSM with timeout, byte FIFO
// and strobe output stage. Define PS2_PARITY_CHECK_EN to reject bad parity.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rec_hold,
    output logic [DATA_BITS-1:0]          ps2dis_data,
    output logic                          ps2dis_recFlag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = $clog2(DATA_BITS);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic                 pclk_s1_q, pclk_s2_q, pclk_h_q;
    logic                 pdat_s1_q, pdat_s2_q;
    ps2_state_e           state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 recflag_q, recflag_d;

    logic                 edge_ev, timed_out, frame_good;
    logic                 fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    assign edge_ev    = pclk_h_q & ~pclk_s2_q;
    assign timed_out  = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));
    assign frame_good = (pdat_s2_q == STOP_BIT) &&
                        (odd_ones({parity_q, shift_q}) || !PARITY_EN);

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (shift_q),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        frame_err_d = 1'b0;
        fifo_wr     = 1'b0;

        if (edge_ev || state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if (!timed_out) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = tmo_q;
        end

        if (edge_ev) begin
            case (state_q)
                ST_IDLE: begin
                    if (pdat_s2_q == START_BIT) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {pdat_s2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = pdat_s2_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    fifo_wr     = frame_good;
                    frame_err_d = ~frame_good;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timed_out) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end

        // Skipping a cycle after each strobe gives the consumer time to settle.
        fifo_rd    = ~fifo_empty & ~rec_hold & ~recflag_q;
        recflag_d  = fifo_rd;
        data_d     = fifo_rd ? fifo_rd_data : data_q;
        overflow_d = overflow_q | (fifo_wr & fifo_full & ~fifo_rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_s1_q   <= 1'b1;
            pclk_s2_q   <= 1'b1;
            pclk_h_q    <= 1'b1;
            pdat_s1_q   <= 1'b1;
            pdat_s2_q   <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            data_q      <= '0;
            recflag_q   <= 1'b0;
        end else begin
            pclk_s1_q   <= ps2_clk;
            pclk_s2_q   <= pclk_s1_q;
            pclk_h_q    <= pclk_s2_q;
            pdat_s1_q   <= ps2_data;
            pdat_s2_q   <= pdat_s1_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            data_q      <= data_d;
            recflag_q   <= recflag_d;
        end
    end

    assign ps2dis_data    = data_q;
    assign ps2dis_recFlag = recflag_q;
    assign overflow       = overflow_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_ps2_receiver;

    localparam int unsigned FIFO_DEPTH     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 200;
    localparam int unsigned CW             = $clog2(FIFO_DEPTH) + 1;
    localparam int          PIN_TO_STROBE  = 4;
    localparam int          PIN_TO_ERR     = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          rec_hold = 1'b0;
    logic [7:0]    ps2dis_data;
    logic          ps2dis_recFlag;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          frame_err;

    ps2_receiver #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .rec_hold       (rec_hold),
        .ps2dis_data    (ps2dis_data),
        .ps2dis_recFlag (ps2dis_recFlag),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] strobe_q[$];
    int         strobe_cyc[$];
    int         ferr_cyc[$];
    int         adj_cnt = 0;
    bit         prev_flag = 1'b0;
    int         last_fall = 0;

    // Output monitor, sampling on the inactive edge.
    always @(negedge clk) begin
        if (rst) begin
            if (ps2dis_recFlag) begin
                strobe_q.push_back(ps2dis_data);
                strobe_cyc.push_back(cyc);
                if (prev_flag) adj_cnt++;
            end
            if (frame_err) ferr_cyc.push_back(cyc);
            prev_flag = ps2dis_recFlag;
        end else begin
            prev_flag = 1'b0;
        end
    end

    task automatic clear_mon();
        strobe_q.delete();
        strobe_cyc.delete();
        ferr_cyc.delete();
        adj_cnt = 0;
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^d) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(~bad_stop);
        @(negedge clk) ps2_data = 1'b1;
    endtask

    // Frame acceptance rule from the protocol definition.
    function automatic bit model_good(input logic [7:0] d, input logic p, input logic stop);
        bit par_ok;
        bit par_en;
        par_ok = ($countones({d, p}) % 2) == 1;
`ifdef PS2_PARITY_CHECK_EN
        par_en = 1'b1;
`else
        par_en = 1'b0;
`endif
        return stop && (par_ok || !par_en);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ps2dis_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ps2dis_data); end
        checks++; if (ps2dis_recFlag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", ps2dis_recFlag); end
        checks++; if (fifo_count !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_frame();
        clear_mon();
        send_frame(8'h1C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (strobe_q.size() !== 1) begin failures++; $display("FAIL good_count got=%0d exp=1", strobe_q.size()); end
        else begin
            checks++; if (strobe_q[0] !== 8'h1C) begin failures++; $display("FAIL good_data got=%h exp=1c", strobe_q[0]); end
            checks++; if (strobe_cyc[0] !== last_fall + PIN_TO_STROBE) begin failures++; $display("FAIL good_latency got=%0d exp=%0d", strobe_cyc[0], last_fall + PIN_TO_STROBE); end
        end
        checks++; if (ferr_cyc.size() !== 0) begin failures++; $display("FAIL good_ferr got=%0d exp=0", ferr_cyc.size()); end
    endtask

    task automatic test_break_seq();
        clear_mon();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (strobe_q.size() !== 2) begin failures++; $display("FAIL break_count got=%0d exp=2", strobe_q.size()); end
        else begin
            checks++; if (strobe_q[0] !== 8'hF0) begin failures++; $display("FAIL break_first got=%h exp=f0", strobe_q[0]); end
            checks++; if (strobe_q[1] !== 8'h1C) begin failures++; $display("FAIL break_second got=%h exp=1c", strobe_q[1]); end
            checks++; if (strobe_cyc[1] - strobe_cyc[0] < 2) begin failures++; $display("FAIL break_gap got=%0d exp>=2", strobe_cyc[1] - strobe_cyc[0]); end
        end
    endtask

    task automatic test_bad_parity();
        int exp_strobes;
        int exp_errs;
`ifdef PS2_PARITY_CHECK_EN
        exp_strobes = 0; exp_errs = 1;
`else
        exp_strobes = 1; exp_errs = 0;
`endif
        clear_mon();
        send_frame(8'h1C, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (strobe_q.size() !== exp_strobes) begin failures++; $display("FAIL parity_strobes got=%0d exp=%0d", strobe_q.size(), exp_strobes); end
        else if (exp_strobes == 1) begin
            checks++; if (strobe_q[0] !== 8'h1C) begin failures++; $display("FAIL parity_data got=%h exp=1c", strobe_q[0]); end
        end
        checks++; if (ferr_cyc.size() !== exp_errs) begin failures++; $display("FAIL parity_ferr got=%0d exp=%0d", ferr_cyc.size(), exp_errs); end
    endtask

    task automatic test_bad_stop();
        clear_mon();
        send_frame(8'h1C, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (strobe_q.size() !== 0) begin failures++; $display("FAIL stop_strobes got=%0d exp=0", strobe_q.size()); end
        checks++; if (ferr_cyc.size() !== 1) begin failures++; $display("FAIL stop_ferr_count got=%0d exp=1", ferr_cyc.size()); end
        else begin
            checks++; if (ferr_cyc[0] !== last_fall + PIN_TO_ERR) begin failures++; $display("FAIL stop_ferr_time got=%0d exp=%0d", ferr_cyc[0], last_fall + PIN_TO_ERR); end
        end
    endtask

    task automatic test_timeout();
        int fall;
        clear_mon();
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        fall = last_fall;
        repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
        checks++; if (ferr_cyc.size() !== 1) begin failures++; $display("FAIL tmo_ferr_count got=%0d exp=1", ferr_cyc.size()); end
        else begin
            checks++;
            if (ferr_cyc[0] < fall + int'(TIMEOUT_CYCLES) || ferr_cyc[0] > fall + int'(TIMEOUT_CYCLES) + 8) begin
                failures++; $display("FAIL tmo_ferr_time got=%0d exp=%0d..%0d", ferr_cyc[0], fall + int'(TIMEOUT_CYCLES), fall + int'(TIMEOUT_CYCLES) + 8);
            end
        end
        checks++; if (strobe_q.size() !== 0) begin failures++; $display("FAIL tmo_strobes got=%0d exp=0", strobe_q.size()); end
        clear_mon();
        send_frame(8'h12, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (strobe_q.size() !== 1 || strobe_q[0] !== 8'h12) begin failures++; $display("FAIL tmo_recover got_n=%0d exp=1 byte 12", strobe_q.size()); end
    endtask

    task automatic test_overflow();
        clear_mon();
        @(negedge clk) rec_hold = 1'b1;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (fifo_count !== CW'(FIFO_DEPTH)) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", fifo_count, FIFO_DEPTH); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (strobe_q.size() !== 0) begin failures++; $display("FAIL ovf_held got=%0d exp=0", strobe_q.size()); end
        @(negedge clk) rec_hold = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (strobe_q.size() !== FIFO_DEPTH) begin failures++; $display("FAIL ovf_drain got=%0d exp=%0d", strobe_q.size(), FIFO_DEPTH); end
        else begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                checks++; if (strobe_q[i] !== 8'(i + 1)) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, strobe_q[i], 8'(i + 1)); end
            end
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
                checks++; if (strobe_cyc[i+1] - strobe_cyc[i] !== 2) begin failures++; $display("FAIL ovf_spacing%0d got=%0d exp=2", i, strobe_cyc[i+1] - strobe_cyc[i]); end
            end
        end
        checks++; if (fifo_count !== CW'(0)) begin failures++; $display("FAIL ovf_empty got=%0d exp=0", fifo_count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_midframe();
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (ps2dis_data !== 8'h00) begin failures++; $display("FAIL mrst_data got=%h exp=00", ps2dis_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mrst_overflow got=%b exp=0", overflow); end
        checks++; if (fifo_count !== CW'(0) || ps2dis_recFlag !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL mrst_misc got count=%0d flag=%b ferr=%b exp=0/0/0", fifo_count, ps2dis_recFlag, frame_err);
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        clear_mon();
        repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
        send_frame(8'h45, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (ferr_cyc.size() !== 0) begin failures++; $display("FAIL mrst_ferr got=%0d exp=0", ferr_cyc.size()); end
        checks++; if (strobe_q.size() !== 1 || strobe_q[0] !== 8'h45) begin failures++; $display("FAIL mrst_next got_n=%0d exp=1 byte 45", strobe_q.size()); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_err;
        logic [7:0] d;
        bit         bp, bs;
        exp_err = 0;
        clear_mon();
        for (int n = 0; n < 10; n++) begin
            d  = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 7) == 0);
            if (model_good(d, ~(^d) ^ bp, ~bs)) exp_q.push_back(d);
            else exp_err++;
            send_frame(d, bp, bs);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++; if (ferr_cyc.size() !== exp_err) begin failures++; $display("FAIL rand_ferr got=%0d exp=%0d", ferr_cyc.size(), exp_err); end
        checks++; if (strobe_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", strobe_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (strobe_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, strobe_q[i], exp_q[i]); end
            end
        end
        checks++; if (adj_cnt !== 0) begin failures++; $display("FAIL rand_adjacent got=%0d exp=0", adj_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_break_seq();
        test_bad_parity();
        test_bad_stop();
        test_timeout();
        test_random();
        test_overflow();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
